n3_brick_encoder: RTL and testbench

//  Parametrised zero-free brick encoder for the convpress output path. Takes TN lanes of N-bit

---
 rtl/n3_defs_pkg.sv | 34 +++
 rtl/n3_enc_lane.sv | 81 ++++++++
 rtl/n3_brick_encoder.sv | 139 +++++++++++++
 tb/tb_n3_brick_encoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n3_defs_pkg.sv
// Shared definitions for the zero-free brick encoder: FSM encoding, clog2 helper
// and {offset,value} pair-word macros.
`ifndef N3_DEFS_PKG_SV
`define N3_DEFS_PKG_SV

`define N3_PACK_PAIR(off, val) {(off), (val)}
`define N3_PAIR_VAL(word, vw) ((word) & ((1 << (vw)) - 1))
`define N3_PAIR_OFF(word, vw) ((word) >> (vw))

package n3_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [1:0] state;
    logic       busy;
  } n3_status_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 32'sd1;
      end
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/n3_enc_lane.sv
// One encoder lane: non-zero counter, pending write register and the
// brick-relative address adder for a single SRAM bank.
module n3_enc_lane
  import n3_defs::*;
#(
  parameter int N         = 16,
  parameter int ADDR_SIZE = 16,
  parameter int OFF_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adv,
  input  logic                   accept,
  input  logic                   brick_end,
  input  logic [OFF_W-1:0]       offset,
  input  logic [ADDR_SIZE-1:0]   brick_addr,
  input  logic [N-1:0]           value,
  output logic                   wr_en,
  output logic [ADDR_SIZE-1:0]   wr_addr,
  output logic [OFF_W+N-1:0]     wr_data,
  output logic [OFF_W:0]         cnt
);

  logic [OFF_W:0]       nz_r;
  logic [OFF_W:0]       nz_next_s;
  logic                 nonzero_s;
  logic [ADDR_SIZE-1:0] addr_s;

  // Next non-zero count and the packed slot address for the current value.
  always_comb begin
    nonzero_s = (value != {N{1'b0}});
    nz_next_s = nz_r + {{OFF_W{1'b0}}, nonzero_s};
    addr_s    = brick_addr + ADDR_SIZE'(nz_r);
  end

  // Per-brick non-zero counter; cleared as the last beat of a brick is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      nz_r <= {(OFF_W+1){1'b0}};
    end else if (accept) begin
      nz_r <= brick_end ? {(OFF_W+1){1'b0}} : nz_next_s;
    end else begin
      nz_r <= nz_r;
    end
  end

  // Count snapshot of the finished brick, including its final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {(OFF_W+1){1'b0}};
    end else if (accept && brick_end) begin
      cnt <= nz_next_s;
    end else begin
      cnt <= cnt;
    end
  end

  // Write register: held while the SRAM stalls, otherwise reloaded or cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= {ADDR_SIZE{1'b0}};
      wr_data <= {(OFF_W+N){1'b0}};
    end else if (adv) begin
      if (accept) begin
        wr_en   <= nonzero_s;
        wr_addr <= addr_s;
        wr_data <= `N3_PACK_PAIR(offset, value);
      end else begin
        wr_en   <= 1'b0;
        wr_addr <= {ADDR_SIZE{1'b0}};
        wr_data <= {(OFF_W+N){1'b0}};
      end
    end else begin
      wr_en   <= wr_en;
      wr_addr <= wr_addr;
      wr_data <= wr_data;
    end
  end

endmodule

// File: rtl/n3_brick_encoder.sv
// Zero-free brick encoder: run FSM, beat/brick counters and SRAM handshake
// around TN independent lane encoders.
module n3_brick_encoder
  import n3_defs::*;
#(
  parameter int N         = 16,
  parameter int TN        = 16,
  parameter int ADDR_SIZE = 16,
  parameter int BRICK     = 16,
  parameter int NB_W      = 16,
  parameter int OFF_W     = clog2(BRICK)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [ADDR_SIZE-1:0]        i_base_addr,
  input  logic [NB_W-1:0]             i_num_bricks,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [TN*N-1:0]             i_data,
  output logic [TN-1:0]               o_wr_en,
  output logic [TN*ADDR_SIZE-1:0]     o_wr_addr,
  output logic [TN*(OFF_W+N)-1:0]     o_wr_data,
  input  logic                        i_wr_ready,
  output logic                        o_cnt_valid,
  output logic [TN*(OFF_W+1)-1:0]     o_cnt,
  output logic                        o_busy,
  output logic                        o_done
);

  logic [1:0]           state_r;
  logic [OFF_W-1:0]     offset_r;
  logic [NB_W-1:0]      brick_cnt_r;
  logic [ADDR_SIZE-1:0] base_r;
  logic [NB_W-1:0]      num_r;
  logic                 cnt_valid_r;
  logic                 done_r;

  logic                 pending_s;
  logic                 adv_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 brick_end_s;
  logic                 last_beat_s;
  logic [ADDR_SIZE-1:0] brick_addr_s;

  // Handshake and brick-boundary decode; BRICK is a power of two so the
  // brick offset is a plain shift of brick_cnt.
  always_comb begin
    pending_s    = |o_wr_en;
    adv_s        = !pending_s || i_wr_ready;
    ready_s      = (state_r == ST_RUN) && adv_s;
    accept_s     = i_valid && ready_s;
    brick_end_s  = accept_s && (offset_r == OFF_W'(BRICK - 1));
    last_beat_s  = brick_end_s && (brick_cnt_r == (num_r - {{(NB_W-1){1'b0}}, 1'b1}));
    brick_addr_s = base_r + ADDR_SIZE'({brick_cnt_r, {OFF_W{1'b0}}});
  end

  // Run FSM with offset / brick counters and the latched run parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      offset_r    <= {OFF_W{1'b0}};
      brick_cnt_r <= {NB_W{1'b0}};
      base_r      <= {ADDR_SIZE{1'b0}};
      num_r       <= {NB_W{1'b0}};
      cnt_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cnt_valid_r <= brick_end_s;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            if (i_num_bricks != {NB_W{1'b0}}) begin
              state_r     <= ST_RUN;
              base_r      <= i_base_addr;
              num_r       <= i_num_bricks;
              offset_r    <= {OFF_W{1'b0}};
              brick_cnt_r <= {NB_W{1'b0}};
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (brick_end_s) begin
              offset_r    <= {OFF_W{1'b0}};
              brick_cnt_r <= brick_cnt_r + {{(NB_W-1){1'b0}}, 1'b1};
            end else begin
              offset_r <= offset_r + OFF_W'(1'b1);
            end
            if (last_beat_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Final writes leave the register on this edge when the SRAM is ready.
          if (adv_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready     = ready_s;
  assign o_cnt_valid = cnt_valid_r;
  assign o_done      = done_r;
  assign o_busy      = (state_r != ST_IDLE);

  for (genvar l = 0; l < TN; l++) begin : g_lane
    n3_enc_lane #(
      .N         (N),
      .ADDR_SIZE (ADDR_SIZE),
      .OFF_W     (OFF_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv_s),
      .accept     (accept_s),
      .brick_end  (brick_end_s),
      .offset     (offset_r),
      .brick_addr (brick_addr_s),
      .value      (i_data[l*N +: N]),
      .wr_en      (o_wr_en[l]),
      .wr_addr    (o_wr_addr[l*ADDR_SIZE +: ADDR_SIZE]),
      .wr_data    (o_wr_data[l*(OFF_W+N) +: (OFF_W+N)]),
      .cnt        (o_cnt[l*(OFF_W+1) +: (OFF_W+1)])
    );
  end

endmodule

// File: tb/tb_n3_brick_encoder.sv
// Directed self-checking bench for n3_brick_encoder (TN=4, N=16, BRICK=4).
module tb_n3_brick_encoder;

  localparam int N = 16, TN = 4, AW = 16, BRICK = 4, NB_W = 16, OFF_W = 2;
  localparam int DW = OFF_W + N, CW = OFF_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [AW-1:0]     i_base_addr = '0;
  logic [NB_W-1:0]   i_num_bricks = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [TN*N-1:0]   i_data = '0;
  logic [TN-1:0]     o_wr_en;
  logic [TN*AW-1:0]  o_wr_addr;
  logic [TN*DW-1:0]  o_wr_data;
  logic              i_wr_ready = 1'b1;
  logic              o_cnt_valid;
  logic [TN*CW-1:0]  o_cnt;
  logic              o_busy;
  logic              o_done;

  n3_brick_encoder #(.N(N), .TN(TN), .ADDR_SIZE(AW), .BRICK(BRICK), .NB_W(NB_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_bricks(i_num_bricks), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_wr_ready(i_wr_ready), .o_cnt_valid(o_cnt_valid), .o_cnt(o_cnt),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [AW-1:0] log_addr [TN][128];
  logic [DW-1:0] log_data [TN][128];
  int            wr_cnt [TN] = '{0, 0, 0, 0};
  int            cv_cnt = 0;
  int            done_cnt = 0;
  logic [TN*CW-1:0] last_cnt = '0;

  // SRAM-side monitor: a lane write is consumed when pending and ready.
  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < TN; l++) begin
        if (o_wr_en[l] && i_wr_ready && wr_cnt[l] < 128) begin
          log_addr[l][wr_cnt[l]] = o_wr_addr[l*AW +: AW];
          log_data[l][wr_cnt[l]] = o_wr_data[l*DW +: DW];
          wr_cnt[l] = wr_cnt[l] + 1;
        end
      end
      if (o_cnt_valid) begin
        cv_cnt = cv_cnt + 1;
        last_cnt = o_cnt;
      end
      if (o_done) done_cnt = done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [AW-1:0] base, input logic [NB_W-1:0] num);
    i_base_addr = base;
    i_num_bricks = num;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic send_beat(input logic [N-1:0] l0, input logic [N-1:0] l1,
                           input logic [N-1:0] l2, input logic [N-1:0] l3);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data = {l3, l2, l1, l0};
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int lane, input int idx,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, "_addr"}, 64'(log_addr[lane][idx]), 64'(a));
    chk({tag, "_data"}, 64'(log_data[lane][idx]), 64'(d));
  endtask

  int s0 [TN];
  int cv0, dn0;

  task automatic snap();
    for (int l = 0; l < TN; l++) s0[l] = wr_cnt[l];
    cv0 = cv_cnt;
    dn0 = done_cnt;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    chk("rst_wr_en", 64'(o_wr_en), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_cnt", 64'(o_cnt), 64'd0);
    chk("rst_addr", 64'(o_wr_addr), 64'd0);

    // 1: single brick, sparse lane 0
    snap();
    start_run(16'h0100, 16'd1);
    chk("t1_busy", 64'(o_busy), 64'd1);
    send_beat(16'd5, 16'd0, 16'd0, 16'd0);
    send_beat(16'd0, 16'd0, 16'd0, 16'd0);
    send_beat(16'd7, 16'd0, 16'd0, 16'd0);
    send_beat(16'd0, 16'd0, 16'd0, 16'd0);
    tick(4);
    chk("t1_n_lane0", 64'(wr_cnt[0] - s0[0]), 64'd2);
    chk("t1_n_others", 64'((wr_cnt[1] - s0[1]) + (wr_cnt[2] - s0[2]) + (wr_cnt[3] - s0[3])), 64'd0);
    chk_wr("t1_w0", 0, s0[0], 16'h0100, 18'h00005);
    chk_wr("t1_w1", 0, s0[0] + 1, 16'h0101, 18'h20007);
    chk("t1_cnt", 64'(last_cnt), 64'h002);
    chk("t1_cv", 64'(cv_cnt - cv0), 64'd1);
    chk("t1_done", 64'(done_cnt - dn0), 64'd1);
    chk("t1_idle", 64'(o_busy), 64'd0);

    // 2: two dense bricks
    snap();
    start_run(16'h0100, 16'd2);
    for (int b = 0; b < 2 * BRICK; b++) begin
      send_beat(16'(16'h0010 + b), 16'(16'h0020 + b), 16'(16'h0030 + b), 16'(16'h0040 + b));
    end
    tick(4);
    for (int l = 0; l < TN; l++) begin
      chk("t2_n", 64'(wr_cnt[l] - s0[l]), 64'd8);
    end
    for (int k = 0; k < 2 * BRICK; k++) begin
      chk_wr("t2_l2", 2, s0[2] + k, 16'(16'h0100 + k), {2'(k), 16'(16'h0030 + k)});
    end
    chk("t2_b1_l0_addr", 64'(log_addr[0][s0[0] + 4]), 64'h0104);
    chk("t2_b1_l3_addr", 64'(log_addr[3][s0[3] + 7]), 64'h0107);
    chk("t2_cnt", 64'(last_cnt), 64'h924);
    chk("t2_cv", 64'(cv_cnt - cv0), 64'd2);
    chk("t2_done", 64'(done_cnt - dn0), 64'd1);

    // 3: SRAM stall of 3 cycles after the first beat
    snap();
    start_run(16'h0200, 16'd1);
    send_beat(16'd1, 16'h00A0, 16'd0, 16'd0);
    i_wr_ready = 1'b0;
    i_valid = 1'b1;
    i_data = {16'd0, 16'd0, 16'h00A1, 16'd2};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_stall_ready", 64'(o_ready), 64'd0);
      chk("t3_stall_en", 64'(o_wr_en), 64'h3);
      chk("t3_stall_addr", 64'(o_wr_addr[AW-1:0]), 64'h0200);
      chk("t3_stall_data", 64'(o_wr_data[DW-1:0]), 64'h00001);
    end
    tick(1);
    i_wr_ready = 1'b1;
    send_beat(16'd2, 16'h00A1, 16'd0, 16'd0);
    send_beat(16'd0, 16'h00A2, 16'd0, 16'd0);
    send_beat(16'd3, 16'h00A3, 16'd0, 16'd0);
    tick(4);
    chk("t3_n_l0", 64'(wr_cnt[0] - s0[0]), 64'd3);
    chk("t3_n_l1", 64'(wr_cnt[1] - s0[1]), 64'd4);
    chk_wr("t3_l0_0", 0, s0[0], 16'h0200, 18'h00001);
    chk_wr("t3_l0_1", 0, s0[0] + 1, 16'h0201, 18'h10002);
    chk_wr("t3_l0_2", 0, s0[0] + 2, 16'h0202, 18'h30003);
    for (int k = 0; k < BRICK; k++) begin
      chk_wr("t3_l1", 1, s0[1] + k, 16'(16'h0200 + k), {2'(k), 16'(16'h00A0 + k)});
    end
    chk("t3_cnt", 64'(last_cnt), 64'h023);
    chk("t3_done", 64'(done_cnt - dn0), 64'd1);

    // 4: address wrap
    snap();
    start_run(16'hFFFE, 16'd1);
    for (int b = 0; b < BRICK; b++) send_beat(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tick(4);
    for (int l = 0; l < TN; l++) begin
      chk("t4_a0", 64'(log_addr[l][s0[l]]), 64'hFFFE);
      chk("t4_a1", 64'(log_addr[l][s0[l] + 1]), 64'hFFFF);
      chk("t4_a2", 64'(log_addr[l][s0[l] + 2]), 64'h0000);
      chk("t4_a3", 64'(log_addr[l][s0[l] + 3]), 64'h0001);
    end
    chk("t4_data3", 64'(log_data[3][s0[3] + 3]), 64'h30044);

    // 5: zero-brick run, then a start request during RUN
    snap();
    start_run(16'h0300, 16'd0);
    chk("t5_done_now", 64'(o_done), 64'd1);
    chk("t5_busy", 64'(o_busy), 64'd0);
    tick(1);
    chk("t5_done_pulse", 64'(o_done), 64'd0);
    chk("t5_no_writes", 64'(wr_cnt[0] - s0[0]), 64'd0);
    snap();
    start_run(16'h0300, 16'd1);
    send_beat(16'd1, 16'd0, 16'd0, 16'd0);
    start_run(16'h0500, 16'd5);
    chk("t5_still_busy", 64'(o_busy), 64'd1);
    for (int b = 1; b < BRICK; b++) send_beat(16'd1, 16'd0, 16'd0, 16'd0);
    tick(4);
    chk("t5_n", 64'(wr_cnt[0] - s0[0]), 64'd4);
    chk("t5_a0", 64'(log_addr[0][s0[0]]), 64'h0300);
    chk("t5_a3", 64'(log_addr[0][s0[0] + 3]), 64'h0303);
    chk("t5_done", 64'(done_cnt - dn0), 64'd1);
    chk("t5_idle", 64'(o_busy), 64'd0);

    // 6: reset mid-brick, then a fresh run
    start_run(16'h0400, 16'd1);
    send_beat(16'd9, 16'd0, 16'd0, 16'd0);
    send_beat(16'd9, 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_rst_en", 64'(o_wr_en), 64'd0);
    chk("t6_rst_busy", 64'(o_busy), 64'd0);
    chk("t6_rst_ready", 64'(o_ready), 64'd0);
    chk("t6_rst_cnt", 64'(o_cnt), 64'd0);
    chk("t6_rst_data", 64'(o_wr_data), 64'd0);
    snap();
    start_run(16'h0400, 16'd1);
    send_beat(16'd9, 16'd0, 16'd0, 16'd0);
    send_beat(16'd0, 16'd0, 16'd0, 16'd0);
    send_beat(16'd9, 16'd0, 16'd0, 16'd0);
    send_beat(16'd9, 16'd0, 16'd0, 16'd0);
    tick(4);
    chk("t6_n", 64'(wr_cnt[0] - s0[0]), 64'd3);
    chk_wr("t6_w0", 0, s0[0], 16'h0400, 18'h00009);
    chk_wr("t6_w1", 0, s0[0] + 1, 16'h0401, 18'h20009);
    chk_wr("t6_w2", 0, s0[0] + 2, 16'h0402, 18'h30009);
    chk("t6_cnt", 64'(last_cnt), 64'h003);
    chk("t6_done", 64'(done_cnt - dn0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
